// File: rtl/main_function_arbiter.sv
// Round-robin front end that shares one main_function datapath unit between two
// clients: one queued request per client, enable/finish sequencing, watchdog recovery.
//
// state   | meaning
// IDLE    | unit idle, arbitrate among pending clients
// ISSUE   | first enable cycle, watchdog cleared, finish not sampled yet
// WAIT    | enable held, waiting for finish or watchdog expiry
// RELEASE | enable dropped, waiting for unit to drop finish and busy
// RECOVER | unit held in reset, granted request aborted
module main_function_arbiter #(
  parameter int OPERAND_WIDTH = 8,
  parameter int RESULT_WIDTH  = 24,
  parameter int TIMEOUT       = 4096
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req0,
  input  logic [OPERAND_WIDTH-1:0] a0,
  input  logic [OPERAND_WIDTH-1:0] b0,
  input  logic                     req1,
  input  logic [OPERAND_WIDTH-1:0] a1,
  input  logic [OPERAND_WIDTH-1:0] b1,
  output logic                     pending0,
  output logic                     pending1,
  output logic                     done0,
  output logic                     done1,
  output logic                     err0,
  output logic                     err1,
  output logic [RESULT_WIDTH-1:0]  result0,
  output logic [RESULT_WIDTH-1:0]  result1,
  output logic                     grant,
  output logic                     active,
  output logic                     fn_enable,
  output logic                     fn_reset,
  output logic [OPERAND_WIDTH-1:0] fn_a,
  output logic [OPERAND_WIDTH-1:0] fn_b,
  input  logic                     fn_busy,
  input  logic                     fn_finish,
  input  logic [RESULT_WIDTH-1:0]  fn_result
);

  localparam int WD_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    RELEASE,
    RECOVER
  } state_t;

  state_t                   state_q, state_d;
  logic                     grant_q, grant_d;
  logic                     last_q, last_d;
  logic [WD_W-1:0]          wd_q, wd_d;
  logic                     pending0_q, pending0_d;
  logic                     pending1_q, pending1_d;
  logic [OPERAND_WIDTH-1:0] a0_q, a0_d, b0_q, b0_d;
  logic [OPERAND_WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
  logic [OPERAND_WIDTH-1:0] fn_a_q, fn_a_d, fn_b_q, fn_b_d;
  logic                     done0_q, done0_d, done1_q, done1_d;
  logic                     err0_q, err0_d, err1_q, err1_d;
  logic [RESULT_WIDTH-1:0]  result0_q, result0_d, result1_q, result1_d;
  logic                     clr0, clr1;
  logic                     pick;
  logic                     accept0, accept1;

  // With both pending the client that was not served last wins.
  assign pick = (pending0_q && pending1_q) ? ~last_q : pending1_q;

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    wd_d      = wd_q;
    fn_a_d    = fn_a_q;
    fn_b_d    = fn_b_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    result0_d = result0_q;
    result1_d = result1_q;
    clr0      = 1'b0;
    clr1      = 1'b0;

    case (state_q)
      IDLE: begin
        if (pending0_q || pending1_q) begin
          grant_d = pick;
          fn_a_d  = pick ? a1_q : a0_q;
          fn_b_d  = pick ? b1_q : b0_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (fn_finish) begin
          if (grant_q) begin
            result1_d = fn_result;
            done1_d   = 1'b1;
            clr1      = 1'b1;
          end else begin
            result0_d = fn_result;
            done0_d   = 1'b1;
            clr0      = 1'b1;
          end
          last_d  = grant_q;
          state_d = RELEASE;
        end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
          // Abort is flagged on entry to RECOVER so err lines up with fn_reset.
          if (grant_q) begin
            err1_d = 1'b1;
            clr1   = 1'b1;
          end else begin
            err0_d = 1'b1;
            clr0   = 1'b1;
          end
          last_d  = grant_q;
          state_d = RECOVER;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      RELEASE: begin
        if (!fn_finish && !fn_busy) begin
          state_d = IDLE;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A request landing in the same cycle its predecessor retires is accepted.
  assign accept0 = req0 && (!pending0_q || clr0);
  assign accept1 = req1 && (!pending1_q || clr1);

  always_comb begin
    pending0_d = (pending0_q && !clr0) || accept0;
    pending1_d = (pending1_q && !clr1) || accept1;
    a0_d       = accept0 ? a0 : a0_q;
    b0_d       = accept0 ? b0 : b0_q;
    a1_d       = accept1 ? a1 : a1_q;
    b1_d       = accept1 ? b1 : b1_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      last_q     <= 1'b1;
      wd_q       <= '0;
      pending0_q <= 1'b0;
      pending1_q <= 1'b0;
      a0_q       <= '0;
      b0_q       <= '0;
      a1_q       <= '0;
      b1_q       <= '0;
      fn_a_q     <= '0;
      fn_b_q     <= '0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      err0_q     <= 1'b0;
      err1_q     <= 1'b0;
      result0_q  <= '0;
      result1_q  <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      wd_q       <= wd_d;
      pending0_q <= pending0_d;
      pending1_q <= pending1_d;
      a0_q       <= a0_d;
      b0_q       <= b0_d;
      a1_q       <= a1_d;
      b1_q       <= b1_d;
      fn_a_q     <= fn_a_d;
      fn_b_q     <= fn_b_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      err0_q     <= err0_d;
      err1_q     <= err1_d;
      result0_q  <= result0_d;
      result1_q  <= result1_d;
    end
  end

  assign pending0  = pending0_q;
  assign pending1  = pending1_q;
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign result0   = result0_q;
  assign result1   = result1_q;
  assign grant     = grant_q;
  assign active    = (state_q != IDLE);
  assign fn_enable = (state_q == ISSUE) || (state_q == WAIT);
  assign fn_reset  = reset || (state_q == RECOVER);
  assign fn_a      = fn_a_q;
  assign fn_b      = fn_b_q;

endmodule

// File: tb/tb_main_function_arbiter.sv
// Directed bench for main_function_arbiter: a behavioural unit multiplies a*b,
// stimulus queues expected done/err events, a monitor pops and compares them.
module tb_main_function_arbiter;

  logic        clock;
  logic        reset;
  logic        req0, req1;
  logic [7:0]  a0, b0, a1, b1;
  logic        pending0, pending1, done0, done1, err0, err1;
  logic [23:0] result0, result1;
  logic        grant, active, fn_enable, fn_reset;
  logic [7:0]  fn_a, fn_b;
  logic        fn_busy, fn_finish;
  logic [23:0] fn_result;

  main_function_arbiter #(
    .OPERAND_WIDTH(8),
    .RESULT_WIDTH (24),
    .TIMEOUT      (16)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .req0     (req0),
    .a0       (a0),
    .b0       (b0),
    .req1     (req1),
    .a1       (a1),
    .b1       (b1),
    .pending0 (pending0),
    .pending1 (pending1),
    .done0    (done0),
    .done1    (done1),
    .err0     (err0),
    .err1     (err1),
    .result0  (result0),
    .result1  (result1),
    .grant    (grant),
    .active   (active),
    .fn_enable(fn_enable),
    .fn_reset (fn_reset),
    .fn_a     (fn_a),
    .fn_b     (fn_b),
    .fn_busy  (fn_busy),
    .fn_finish(fn_finish),
    .fn_result(fn_result)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          client;
    bit          is_err;
    logic [23:0] value;
  } exp_t;
  exp_t exp_q[$];

  // unit model controls
  int u_delay    = 10;
  int u_hold_cfg = 0;
  int u_hold     = 0;
  int u_cnt      = 0;
  bit u_hang     = 1'b0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, got stuck expected completion");
    $fatal(1, "timeout");
  end

  // Behavioural datapath unit, updated just after each rising edge.
  initial begin
    fn_busy   = 1'b0;
    fn_finish = 1'b0;
    fn_result = '0;
    forever begin
      @(posedge clock);
      #1;
      if (fn_reset) begin
        u_cnt     = 0;
        fn_finish = 1'b0;
        fn_busy   = 1'b0;
      end else if (fn_enable) begin
        if (!fn_finish) begin
          u_cnt++;
          fn_busy = 1'b1;
          if (!u_hang && u_cnt >= u_delay) begin
            fn_finish = 1'b1;
            fn_busy   = 1'b0;
            fn_result = 24'(fn_a) * 24'(fn_b);
            u_hold    = u_hold_cfg;
          end
        end
      end else begin
        u_cnt   = 0;
        fn_busy = 1'b0;
        if (fn_finish) begin
          if (u_hold > 0) u_hold--;
          else fn_finish = 1'b0;
        end
      end
    end
  end

  // Scoreboard monitor
  logic        mon_d, mon_e;
  logic [23:0] mon_r;
  exp_t        mon_x;
  always @(negedge clock) begin
    for (int c = 0; c < 2; c++) begin
      mon_d = (c == 1) ? done1 : done0;
      mon_e = (c == 1) ? err1 : err0;
      mon_r = (c == 1) ? result1 : result0;
      if (mon_d === 1'b1 && mon_e === 1'b1) begin
        checks++;
        errors++;
        $display("FAIL done_err_both client%0d: got done=1 err=1 expected at most one", c);
      end else if (mon_d === 1'b1 || mon_e === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event client%0d: got done=%0b err=%0b expected none", c, mon_d, mon_e);
        end else begin
          mon_x = exp_q.pop_front();
          if (mon_x.client != c || mon_x.is_err != mon_e || mon_r !== mon_x.value) begin
            errors++;
            $display("FAIL sb_event: got client%0d err=%0b result=%h expected client%0d err=%0b result=%h",
                     c, mon_e, mon_r, mon_x.client, mon_x.is_err, mon_x.value);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int c, input bit e, input logic [23:0] v);
    exp_t x;
    x.client = c;
    x.is_err = e;
    x.value  = v;
    exp_q.push_back(x);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((active !== 1'b0 || pending0 !== 1'b0 || pending1 !== 1'b0) && n < 600) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_idle_timeout"}, 32'(n < 600), 32'd1);
  endtask

  task automatic wait_flag(input int c, input string name);
    int n = 0;
    while (((c == 1) ? (done1 | err1) : (done0 | err0)) !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    chk({name, "_event_timeout"}, 32'(n < 400), 32'd1);
  endtask

  task automatic round(input logic [7:0] x0, input logic [7:0] y0, input logic [7:0] x1,
                       input logic [7:0] y1, input int first, input logic [23:0] e0,
                       input logic [23:0] e1);
    if (first == 0) begin
      push_exp(0, 1'b0, e0);
      push_exp(1, 1'b0, e1);
    end else begin
      push_exp(1, 1'b0, e1);
      push_exp(0, 1'b0, e0);
    end
    @(negedge clock);
    a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    req0 = 1'b1;
    req1 = 1'b1;
    @(negedge clock);
    req0 = 1'b0;
    req1 = 1'b0;
    @(negedge clock);
    chk("round_first_grant", 32'(grant), 32'(first));
    chk("round_first_enable", 32'(fn_enable), 32'd1);
    wait_idle("round");
  endtask

  task automatic single(input int c, input logic [7:0] x, input logic [7:0] y, input logic [23:0] e);
    push_exp(c, 1'b0, e);
    @(negedge clock);
    if (c == 1) begin
      a1 = x; b1 = y; req1 = 1'b1;
    end else begin
      a0 = x; b0 = y; req0 = 1'b1;
    end
    @(negedge clock);
    req0 = 1'b0;
    req1 = 1'b0;
    wait_idle("single");
  endtask

  initial begin
    int n;
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;

    // reset state
    @(negedge clock);
    @(negedge clock);
    chk("rst_pending0", 32'(pending0), 32'd0);
    chk("rst_pending1", 32'(pending1), 32'd0);
    chk("rst_active", 32'(active), 32'd0);
    chk("rst_fn_enable", 32'(fn_enable), 32'd0);
    chk("rst_fn_reset", 32'(fn_reset), 32'd1);
    chk("rst_result0", 32'(result0), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_fn_a", 32'(fn_a), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("fn_reset_released", 32'(fn_reset), 32'd0);

    // single request, latency and pulse shape
    push_exp(0, 1'b0, 24'h000054);
    a0 = 8'd12; b0 = 8'd7; req0 = 1'b1;
    @(negedge clock);
    req0 = 1'b0;
    chk("t1_pending_set", 32'(pending0), 32'd1);
    chk("t1_enable_not_yet", 32'(fn_enable), 32'd0);
    @(negedge clock);
    chk("t1_enable_latency", 32'(fn_enable), 32'd1);
    chk("t1_grant", 32'(grant), 32'd0);
    chk("t1_fn_a", 32'(fn_a), 32'd12);
    chk("t1_fn_b", 32'(fn_b), 32'd7);
    wait_flag(0, "t1");
    chk("t1_pending_clear", 32'(pending0), 32'd0);
    chk("t1_enable_dropped", 32'(fn_enable), 32'd0);
    @(negedge clock);
    chk("t1_done_one_cycle", 32'(done0), 32'd0);
    chk("t1_result0_held", 32'(result0), 32'h54);
    chk("t1_result1_zero", 32'(result1), 32'd0);
    wait_idle("t1");

    // round-robin alternation
    do_reset();
    round(8'd3, 8'd5, 8'd10, 8'd20, 0, 24'h00000F, 24'h0000C8);
    round(8'd255, 8'd255, 8'd0, 8'd9, 0, 24'h00FE01, 24'h000000);
    single(0, 8'd16, 8'd16, 24'h000100);
    round(8'd7, 8'd9, 8'd11, 8'd13, 1, 24'h00003F, 24'h00008F);
    round(8'd128, 8'd2, 8'd200, 8'd3, 1, 24'h000100, 24'h000258);

    // repeated request ignored, coincident-with-done request accepted
    push_exp(0, 1'b0, 24'h000018);
    @(negedge clock);
    a0 = 8'd4; b0 = 8'd6; req0 = 1'b1;
    @(negedge clock);
    a0 = 8'd9; b0 = 8'd9;
    @(negedge clock);
    req0 = 1'b0;
    chk("t3_fn_a_kept", 32'(fn_a), 32'd4);
    chk("t3_fn_b_kept", 32'(fn_b), 32'd6);
    @(negedge clock);
    a0 = 8'd1; b0 = 8'd1; req0 = 1'b1;
    @(negedge clock);
    req0 = 1'b0;
    chk("t3_fn_a_wait", 32'(fn_a), 32'd4);
    n = 0;
    while (fn_finish !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("t3_finish_timeout", 32'(n < 100), 32'd1);
    push_exp(0, 1'b0, 24'h000028);
    a0 = 8'd5; b0 = 8'd8; req0 = 1'b1;
    @(negedge clock);
    req0 = 1'b0;
    chk("t3_done_with_req", 32'(done0), 32'd1);
    chk("t3_pending_rearmed", 32'(pending0), 32'd1);
    wait_idle("t3");

    // watchdog recovery, then client 1 served normally
    push_exp(0, 1'b1, 24'h000028);
    push_exp(1, 1'b0, 24'h00000C);
    u_hang = 1'b1;
    @(negedge clock);
    a0 = 8'd1; b0 = 8'd2; req0 = 1'b1;
    @(negedge clock);
    req0 = 1'b0;
    a1 = 8'd3; b1 = 8'd4; req1 = 1'b1;
    @(negedge clock);
    req1 = 1'b0;
    n = 0;
    while (fn_enable === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    chk("t4_enable_cycles", 32'(n), 32'd17);
    chk("t4_err0", 32'(err0), 32'd1);
    chk("t4_fn_reset", 32'(fn_reset), 32'd1);
    u_hang = 1'b0;
    @(negedge clock);
    chk("t4_err_one_cycle", 32'(err0), 32'd0);
    chk("t4_fn_reset_one_cycle", 32'(fn_reset), 32'd0);
    chk("t4_result0_unchanged", 32'(result0), 32'h28);
    wait_idle("t4");

    // finish held after enable drops
    u_hold_cfg = 5;
    push_exp(1, 1'b0, 24'h00002A);
    @(negedge clock);
    a1 = 8'd6; b1 = 8'd7; req1 = 1'b1;
    @(negedge clock);
    req1 = 1'b0;
    wait_flag(1, "t5");
    n = 0;
    while (active === 1'b1 && n < 50) begin
      n++;
      @(negedge clock);
    end
    chk("t5_release_cycles", 32'(n), 32'd6);
    chk("t5_finish_low", 32'(fn_finish), 32'd0);
    u_hold_cfg = 0;

    // reset during WAIT
    @(negedge clock);
    a0 = 8'd2; b0 = 8'd3; req0 = 1'b1;
    @(negedge clock);
    req0 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("t6_in_wait", 32'(fn_enable), 32'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_pending0", 32'(pending0), 32'd0);
    chk("t6_active", 32'(active), 32'd0);
    chk("t6_fn_enable", 32'(fn_enable), 32'd0);
    chk("t6_fn_reset", 32'(fn_reset), 32'd1);
    chk("t6_fn_a", 32'(fn_a), 32'd0);
    chk("t6_result0", 32'(result0), 32'd0);
    chk("t6_result1", 32'(result1), 32'd0);
    chk("t6_done0", 32'(done0), 32'd0);
    chk("t6_err0", 32'(err0), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) @(negedge clock);
    chk("t6_stays_idle", 32'(active), 32'd0);
    single(1, 8'd9, 8'd9, 24'h000051);

    for (int i = 0; i < 5; i++) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
